// File: rtl/nw_align_decoder_if.sv
// Handshake bundle for nw_align_decoder: traceback coordinate stream in,
// aligned-column stream out. The decoder takes the slave side.
interface nw_align_decoder_if #(
  parameter int CWIDTH      = 2,
  parameter int CORD_LENGTH = 8
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [CORD_LENGTH-1:0] in_x;
  logic [CORD_LENGTH-1:0] in_y;
  logic                   out_valid;
  logic                   out_ready;
  logic [CWIDTH-1:0]      out_c1;
  logic [CWIDTH-1:0]      out_c2;
  logic                   out_gap1;
  logic                   out_gap2;
  logic                   out_last;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last
  );
endinterface

// File: rtl/nw_align_decoder.sv
// Needleman-Wunsch traceback decoder: turns a reverse coordinate walk into forward
// alignment columns via a LIFO. Optional score output with macro NW_ALIGN_SCORE_EN.
module nw_align_decoder #(
  parameter int LENGTH      = 10,
  parameter int CWIDTH      = 2,
  parameter int CORD_LENGTH = 8,
  parameter int SWIDTH      = 16,
  parameter int MATCH       = 1,
  parameter int MISMATCH    = -1,
  parameter int INDEL       = -1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LENGTH*CWIDTH-1:0]   s1,
  input  logic [LENGTH*CWIDTH-1:0]   s2,
  nw_align_decoder_if.slave          bus,
  output logic                       done,
  output logic                       err
`ifdef NW_ALIGN_SCORE_EN
  ,
  output logic signed [SWIDTH-1:0]   score
`endif
);

  localparam int DEPTH = 2 * LENGTH - 1;
  localparam int CNT_W = $clog2(2 * LENGTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CORD_LENGTH-1:0] LAST_IDX = CORD_LENGTH'(LENGTH - 1);
  localparam logic [CORD_LENGTH:0]   D_ONE    = (CORD_LENGTH+1)'(1);
  localparam longint WMAX = (longint'(1) << (SWIDTH - 1)) - 1;
  localparam longint WMIN = -WMAX - 1;

  // Reject configurations whose coordinates or weights cannot be represented.
  if (LENGTH < 2 || longint'(LENGTH - 1) >= (longint'(1) << CORD_LENGTH) ||
      SWIDTH < 2 || SWIDTH > 32 ||
      longint'(MATCH) > WMAX || longint'(MATCH) < WMIN ||
      longint'(MISMATCH) > WMAX || longint'(MISMATCH) < WMIN ||
      longint'(INDEL) > WMAX || longint'(INDEL) < WMIN) begin : g_bad_params
    $error("nw_align_decoder: unsupported parameter combination");
  end

  typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              gap1;
    logic              gap2;
    logic [CWIDTH-1:0] c1;
    logic [CWIDTH-1:0] c2;
  } col_t;

  state_t                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   have_prev_q, have_prev_d;
  logic [CORD_LENGTH-1:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [CNT_W-1:0]       count_q, count_d;
  col_t                   out_col_q, out_col_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  col_t                   lifo_q [DEPTH];

  logic                   push0_en, push1_en;
  col_t                   col0, col1;
  logic [CNT_W-1:0]       n_push;
  logic [CORD_LENGTH:0]   dx, dy;
  logic                   step_corner, step_top, step_left, at_origin, in_hs;

  function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] s,
                                                 input logic [CORD_LENGTH-1:0] idx);
    logic [LENGTH*CWIDTH-1:0] t;
    t = s >> (CWIDTH * (LENGTH - 1 - int'(idx)));
    return t[CWIDTH-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    have_prev_d = have_prev_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    count_d     = count_q;
    out_col_d   = out_col_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = done_q;
    err_d       = err_q;
    push0_en    = 1'b0;
    push1_en    = 1'b0;
    n_push      = '0;

    // Nine-bit differences so a step like 0 -> 255 is never mistaken for a legal move.
    dx          = {1'b0, prev_x_q} - {1'b0, bus.in_x};
    dy          = {1'b0, prev_y_q} - {1'b0, bus.in_y};
    step_corner = (dx == D_ONE) && (dy == D_ONE);
    step_top    = (dx == '0)    && (dy == D_ONE);
    step_left   = (dx == D_ONE) && (dy == '0);
    at_origin   = (bus.in_x == '0) && (bus.in_y == '0);
    in_hs       = bus.in_valid && in_ready_q;

    col0      = '0;
    col0.gap1 = step_left;
    col0.gap2 = step_top;
    if (!step_left) col0.c1 = char_at(s1, prev_y_q);
    if (!step_top)  col0.c2 = char_at(s2, prev_x_q);
    col1      = '0;
    col1.c1   = char_at(s1, '0);
    col1.c2   = char_at(s2, '0);

    unique case (state_q)
      FILL: begin
        if (in_hs) begin
          if (!have_prev_q) begin
            if (bus.in_x == LAST_IDX && bus.in_y == LAST_IDX) begin
              have_prev_d = 1'b1;
              prev_x_d    = bus.in_x;
              prev_y_d    = bus.in_y;
            end else begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end else if (!(step_corner || step_top || step_left)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            n_push = at_origin ? CNT_W'(2) : CNT_W'(1);
            if (count_q + n_push > CNT_W'(DEPTH)) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              push0_en = 1'b1;
              push1_en = at_origin;
              count_d  = count_q + n_push;
              prev_x_d = bus.in_x;
              prev_y_d = bus.in_y;
              if (at_origin) state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        // The bottom LIFO entry is the (LENGTH-1, LENGTH-1) column, so it carries last.
        if (count_q != '0 && (!out_valid_q || bus.out_ready)) begin
          out_valid_d = 1'b1;
          out_col_d   = lifo_q[IDX_W'(count_q - CNT_W'(1))];
          out_last_d  = (count_q == CNT_W'(1));
          count_d     = count_q - CNT_W'(1);
        end else if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            done_d     = 1'b1;
            state_d    = DONE;
          end
        end
      end
      default: ;
    endcase

    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      in_ready_q  <= 1'b0;
      have_prev_q <= 1'b0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
      count_q     <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      have_prev_q <= have_prev_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
      count_q     <= count_d;
      out_col_q   <= out_col_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0_en) lifo_q[IDX_W'(count_q)] <= col0;
    if (push1_en) lifo_q[IDX_W'(count_q + CNT_W'(1))] <= col1;
  end

`ifdef NW_ALIGN_SCORE_EN
  logic signed [SWIDTH-1:0] score_q, score_d;

  function automatic logic signed [SWIDTH-1:0] col_weight(input col_t c);
    if (c.gap1 || c.gap2) return SWIDTH'(INDEL);
    if (c.c1 == c.c2)     return SWIDTH'(MATCH);
    return SWIDTH'(MISMATCH);
  endfunction

  always_comb begin
    score_d = score_q;
    if (push0_en) score_d = score_d + col_weight(col0);
    if (push1_en) score_d = score_d + col_weight(col1);
  end

  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_c1    = out_col_q.c1;
  assign bus.out_c2    = out_col_q.c2;
  assign bus.out_gap1  = out_col_q.gap1;
  assign bus.out_gap2  = out_col_q.gap2;
  assign bus.out_last  = out_last_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_nw_align_decoder.sv
// Self-checking bench for nw_align_decoder (LENGTH=4): directed cases plus random
// strings/paths checked against a forward-alignment reference model.
module tb_nw_align_decoder;
  localparam int L  = 4;
  localparam int CW = 2;
  localparam int CL = 8;
  localparam int SW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [L*CW-1:0] s1 = '0;
  logic [L*CW-1:0] s2 = '0;
  logic            done;
  logic            err;
`ifdef NW_ALIGN_SCORE_EN
  logic signed [SW-1:0] score;
`endif

  nw_align_decoder_if #(.CWIDTH(CW), .CORD_LENGTH(CL)) bus ();

  nw_align_decoder #(
    .LENGTH(L), .CWIDTH(CW), .CORD_LENGTH(CL), .SWIDTH(SW),
    .MATCH(1), .MISMATCH(-1), .INDEL(-1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s1    (s1),
    .s2    (s2),
    .bus   (bus),
    .done  (done),
    .err   (err)
`ifdef NW_ALIGN_SCORE_EN
    ,
    .score (score)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
  } coord_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  coord_t      path_q[$];
  logic [6:0]  exp_q[$];
  logic [6:0]  got_q[$];
  int          exp_score;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] ch(input logic [L*CW-1:0] s, input int i);
    logic [L*CW-1:0] t;
    t = s >> (CW * (L - 1 - i));
    return t[CW-1:0];
  endfunction

  // Reference: build the alignment forwards from (0,0) outward, scoring as we go.
  function automatic void build_expected();
    int n;
    logic [CW-1:0] a, b;
    logic g1, g2;
    exp_q.delete();
    exp_score = 0;
    n = path_q.size();
    a = ch(s1, 0);
    b = ch(s2, 0);
    exp_q.push_back({(n == 1), 1'b0, 1'b0, a, b});
    exp_score += (a == b) ? 1 : -1;
    for (int k = n - 2; k >= 0; k--) begin
      int ddx, ddy;
      ddx = path_q[k].x - path_q[k+1].x;
      ddy = path_q[k].y - path_q[k+1].y;
      g1 = (ddy == 0);
      g2 = (ddx == 0);
      a  = g1 ? '0 : ch(s1, path_q[k].y);
      b  = g2 ? '0 : ch(s2, path_q[k].x);
      exp_q.push_back({(k == 0), g1, g2, a, b});
      if (g1 || g2) exp_score -= 1;
      else exp_score += (a == b) ? 1 : -1;
    end
  endfunction

  function automatic void gen_path();
    int x, y, m;
    coord_t c;
    path_q.delete();
    x = L - 1;
    y = L - 1;
    c.x = x; c.y = y;
    path_q.push_back(c);
    while (x != 0 || y != 0) begin
      if (x > 0 && y > 0) m = int'($urandom_range(0, 2));
      else if (x > 0)     m = 2;
      else                m = 1;
      case (m)
        0:       begin x--; y--; end
        1:       y--;
        default: x--;
      endcase
      c.x = x; c.y = y;
      path_q.push_back(c);
    end
  endfunction

  function automatic void set_path(input int xs[$], input int ys[$]);
    coord_t c;
    path_q.delete();
    foreach (xs[i]) begin
      c.x = xs[i]; c.y = ys[i];
      path_q.push_back(c);
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", {bus.out_last, bus.out_gap1, bus.out_gap2, bus.out_c1, bus.out_c2}, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
`ifdef NW_ALIGN_SCORE_EN
    check("rst_score", int'(score), 0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
  endtask

  task automatic send_one(input int x, input int y, output bit ok);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_x = CL'(x);
    bus.in_y = CL'(y);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      check("in_ready_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    ok = 1'b1;
    $display("coord (%0d,%0d) accepted", x, y);
  endtask

  task automatic send_path();
    bit ok;
    foreach (path_q[i]) begin
      send_one(path_q[i].x, path_q[i].y, ok);
      if (!ok) return;
    end
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready
  task automatic collect(input int mode, input int max_beats);
    int k, cyc;
    logic r, v, stalled;
    logic [6:0] d, held;
    k = 0; cyc = 0; stalled = 1'b0; held = '0;
    got_q.delete();
    while (cyc < 200) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((k % 4) == 0) || ((k % 4) == 3);
        default: r = ($urandom_range(0, 9) < 7);
      endcase
      bus.out_ready = r;
      k++;
      v = bus.out_valid;
      d = {bus.out_last, bus.out_gap1, bus.out_gap2, bus.out_c1, bus.out_c2};
      if (stalled) begin
        check("hold_valid", v, 1);
        check("hold_data", d, held);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (v && r) begin
        got_q.push_back(d);
        $display("beat %0d: c1=%0d c2=%0d gap1=%0b gap2=%0b last=%0b",
                 got_q.size() - 1, d[3:2], d[1:0], d[5], d[4], d[6]);
        stalled = 1'b0;
        if (d[6] || got_q.size() >= max_beats) break;
      end else if (v) begin
        stalled = 1'b1;
        held = d;
      end else begin
        stalled = 1'b0;
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_beat_count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  task automatic check_finished(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
`ifdef NW_ALIGN_SCORE_EN
    check({tag, "_score"}, int'(score), exp_score);
`endif
  endtask

  task automatic watch_no_output(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      seen = seen | bus.out_valid;
    end
    check({tag, "_no_output"}, seen, 0);
  endtask

  localparam logic [L*CW-1:0] ACGT = 8'b00_01_10_11;

  initial begin
    bit ok;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;

    // Diagonal case
    s1 = ACGT; s2 = ACGT;
    do_reset();
    set_path('{3, 2, 1, 0}, '{3, 2, 1, 0});
    build_expected();
    send_path();
    collect(0, 20);
    compare_beats("diag");
    check_finished("diag");

    // Gap case
    do_reset();
    set_path('{3, 2, 1, 0, 0}, '{3, 3, 2, 1, 0});
    build_expected();
    send_path();
    collect(0, 20);
    compare_beats("gap");
    check_finished("gap");

    // Backpressure on the diagonal case
    do_reset();
    set_path('{3, 2, 1, 0}, '{3, 2, 1, 0});
    build_expected();
    send_path();
    collect(1, 20);
    compare_beats("bp");
    check_finished("bp");

    // Bad start coordinate
    do_reset();
    send_one(2, 3, ok);
    check("badstart_err", err, 1);
    check("badstart_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    watch_no_output("badstart", 6);
    check("badstart_done", done, 0);
    bus.out_ready = 1'b0;

    // Illegal step (3,3) -> (1,3)
    do_reset();
    send_one(3, 3, ok);
    send_one(1, 3, ok);
    check("illegal_err", err, 1);
    bus.out_ready = 1'b1;
    watch_no_output("illegal", 6);
    check("illegal_in_ready", bus.in_ready, 0);
    check("illegal_done", done, 0);
    bus.out_ready = 1'b0;

    // Wrap-around step 0 -> 255 must be rejected
    do_reset();
    set_path('{3, 2, 1, 0, 255}, '{3, 3, 3, 3, 2});
    send_path();
    check("wrap_err", err, 1);
    check("wrap_in_ready", bus.in_ready, 0);

    // Reset mid-DRAIN after two beats
    do_reset();
    set_path('{3, 2, 1, 0}, '{3, 2, 1, 0});
    build_expected();
    send_path();
    collect(0, 2);
    check("middrain_beats", got_q.size(), 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("middrain_rst_out_valid", bus.out_valid, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("middrain_in_ready", bus.in_ready, 1);
    check("middrain_done", done, 0);
    bus.out_ready = 1'b1;
    watch_no_output("middrain", 6);
    check("middrain_in_ready_hold", bus.in_ready, 1);
    bus.out_ready = 1'b0;

    // Random strings and legal paths with random backpressure
    for (int t = 0; t < 25; t++) begin
      s1 = L*CW'($urandom);
      s2 = L*CW'($urandom);
      gen_path();
      build_expected();
      do_reset();
      send_path();
      collect(2, 20);
      compare_beats($sformatf("rnd%0d", t));
      check_finished($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (observed running, required finished)");
    $fatal(1, "watchdog");
  end

endmodule
